// File: rtl/shift_unit.sv
// shift_unit: ARM-style barrel shifter (LSL/LSR/ASR/ROR/RRX) with full carry-out,
// sitting between operand fetch and the ALU second-operand input.
//
// Build option: define SHIFT_PIPE_EN to put a register after the first
// ceil(log2(WIDTH)/2) mux levels. Latency is then 2 and up to 2 ops are in flight.
// Without it, latency is 1 and up to 1 op is in flight.
// Functional results are the same in both builds.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both 1.
// The producer holds valid and payload steady until the transfer. ready may depend
// combinationally on the downstream ready. valid never depends on ready.
module shift_unit #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic             imm_form,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AMT_W-1:0] amount,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             cout
);
  localparam int LG = $clog2(WIDTH);
  localparam int P  = (LG + 1) / 2;

  localparam logic [1:0]       OP_LSL  = 2'd0;
  localparam logic [1:0]       OP_LSR  = 2'd1;
  localparam logic [1:0]       OP_ASR  = 2'd2;
  localparam logic [1:0]       OP_ROR  = 2'd3;
  localparam logic [AMT_W-1:0] W_AMT   = AMT_W'(WIDTH);
  localparam logic [LG-1:0]    ZERO_LG = '0;
  localparam logic [LG-1:0]    ONE_LG  = LG'(1);

  // One mux level: move every bit by 2**k positions, using the fill rule of the op.
  // Indices wrap modulo WIDTH, so the distance is always below WIDTH.
  function automatic logic [WIDTH-1:0] mux_level(input logic [WIDTH-1:0] x,
                                                 input logic [1:0] o, input int k);
    logic [WIDTH-1:0] y;
    logic [LG-1:0]    up;
    logic [LG-1:0]    dn;
    int               d;
    d = 1 << k;
    y = x;
    for (int i = 0; i < WIDTH; i++) begin
      up = LG'(i + d);
      dn = LG'(i - d);
      case (o)
        OP_LSL:  y[i] = (i >= d) ? x[dn] : 1'b0;
        OP_LSR:  y[i] = (i + d < WIDTH) ? x[up] : 1'b0;
        OP_ASR:  y[i] = (i + d < WIDTH) ? x[up] : x[WIDTH-1];
        default: y[i] = x[up];
      endcase
    end
    return y;
  endfunction

  logic             rrx_e, big_e, gt_e, zero_e, ones_e, cout_e;
  logic [AMT_W-1:0] n_eff;
  logic [LG-1:0]    s_n, s_e, idx_l, idx_r;
  logic [WIDTH-1:0] early;

  // Normalise the amount, then choose the out-of-range overrides and the carry-out.
  always_comb begin
    rrx_e  = imm_form && (amount == '0) && (op == OP_ROR);
    n_eff  = (imm_form && (amount == '0) && (op == OP_LSR || op == OP_ASR)) ? W_AMT : amount;
    s_n    = n_eff[LG-1:0];
    s_e    = rrx_e ? ONE_LG : s_n;
    big_e  = (n_eff >= W_AMT);
    gt_e   = (n_eff > W_AMT);
    ones_e = big_e && (op == OP_ASR) && data_in[WIDTH-1];
    zero_e = big_e && (op != OP_ROR) && !ones_e;
    // Left carry is bit W-n, right carry is bit n-1. Both wrap cleanly when n == W.
    idx_l  = ZERO_LG - s_n;
    idx_r  = s_n - ONE_LG;
    if (rrx_e) begin
      cout_e = data_in[0];
    end else if (n_eff == '0) begin
      cout_e = cin;
    end else begin
      case (op)
        OP_LSL:  cout_e = gt_e ? 1'b0 : data_in[idx_l];
        OP_LSR:  cout_e = gt_e ? 1'b0 : data_in[idx_r];
        OP_ASR:  cout_e = big_e ? data_in[WIDTH-1] : data_in[idx_r];
        default: cout_e = data_in[idx_r];
      endcase
    end
  end

  // First P mux levels, applied directly to the incoming operand.
  always_comb begin
    early = data_in;
    for (int k = 0; k < P; k++)
      if (s_e[k]) early = mux_level(early, op, k);
  end

  logic [WIDTH-1:0] late_data, late, result;
  logic [1:0]       late_op;
  logic [LG-1:P]    late_s;
  logic             late_zero, late_ones, late_rrx, late_cin, late_cout;

  // Apply the remaining mux levels, then the out-of-range and RRX overrides.
  always_comb begin
    late = late_data;
    for (int k = P; k < LG; k++)
      if (late_s[k]) late = mux_level(late, late_op, k);
    if (late_zero)      result = '0;
    else if (late_ones) result = '1;
    else if (late_rrx)  result = {late_cin, late[WIDTH-2:0]};
    else                result = late;
  end

  logic out_adv;
  logic src_valid;

  assign out_adv = !out_valid || out_ready;

`ifdef SHIFT_PIPE_EN
  logic             mid_valid, mid_adv;
  logic [WIDTH-1:0] mid_data;
  logic [1:0]       mid_op;
  logic [LG-1:P]    mid_s;
  logic             mid_zero, mid_ones, mid_rrx, mid_cin, mid_cout;

  assign mid_adv   = !mid_valid || out_adv;
  assign in_ready  = mid_adv;
  assign src_valid = mid_valid;

  // Mid register: takes the half-shifted operand and its side-band whenever it can move on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mid_valid <= 1'b0;
      mid_data  <= '0;
      mid_op    <= '0;
      mid_s     <= '0;
      mid_zero  <= 1'b0;
      mid_ones  <= 1'b0;
      mid_rrx   <= 1'b0;
      mid_cin   <= 1'b0;
      mid_cout  <= 1'b0;
    end else if (mid_adv) begin
      mid_valid <= in_valid;
      if (in_valid) begin
        mid_data <= early;
        mid_op   <= op;
        mid_s    <= s_e[LG-1:P];
        mid_zero <= zero_e;
        mid_ones <= ones_e;
        mid_rrx  <= rrx_e;
        mid_cin  <= cin;
        mid_cout <= cout_e;
      end
    end
  end

  assign late_data = mid_data;
  assign late_op   = mid_op;
  assign late_s    = mid_s;
  assign late_zero = mid_zero;
  assign late_ones = mid_ones;
  assign late_rrx  = mid_rrx;
  assign late_cin  = mid_cin;
  assign late_cout = mid_cout;
`else
  assign in_ready  = out_adv;
  assign src_valid = in_valid;
  assign late_data = early;
  assign late_op   = op;
  assign late_s    = s_e[LG-1:P];
  assign late_zero = zero_e;
  assign late_ones = ones_e;
  assign late_rrx  = rrx_e;
  assign late_cin  = cin;
  assign late_cout = cout_e;
`endif

  // Output register: loads a new result only when the consumer side frees up.
  // While stalled it holds its value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      cout      <= 1'b0;
    end else if (out_adv) begin
      out_valid <= src_valid;
      if (src_valid) begin
        data_out <= result;
        cout     <= late_cout;
      end
    end
  end

endmodule

// File: tb/tb_shift_unit.sv
// tb_shift_unit: checks shift_unit against spec vectors and a bit-serial reference model.
// A WIDTH=32 instance is driven through a scoreboard. A WIDTH=16 instance covers width generality.
module tb_shift_unit;
  localparam int W        = 32;
  localparam int AW       = 8;
  localparam int MAX_WAIT = 200;
  localparam int NV       = 19;

  typedef logic [W:0] res_t;  // {cout, data}

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic        imm;
    logic [31:0] d;
    logic [7:0]  amt;
    logic        cin;
    logic [31:0] exp_d;
    logic        exp_c;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // ---------------- WIDTH=32 instance ----------------
  logic          in_valid, in_ready, imm_form, cin, out_valid, out_ready, cout;
  logic [1:0]    op;
  logic [W-1:0]  data_in, data_out;
  logic [AW-1:0] amount;

  shift_unit #(.WIDTH(W), .AMT_W(AW)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .imm_form(imm_form), .data_in(data_in), .amount(amount), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .cout(cout)
  );

  // ---------------- WIDTH=16 instance ----------------
  logic          in_valid16, in_ready16, imm16, cin16, out_valid16, out_ready16, cout16;
  logic [1:0]    op16;
  logic [15:0]   d16_in, d16_out;
  logic [AW-1:0] amt16;

  shift_unit #(.WIDTH(16), .AMT_W(AW)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16), .op(op16),
    .imm_form(imm16), .data_in(d16_in), .amount(amt16), .cin(cin16),
    .out_valid(out_valid16), .out_ready(out_ready16), .data_out(d16_out), .cout(cout16)
  );

  // ---------------- scoreboard state ----------------
  res_t  exp_q[$];
  string name_q[$];
  int    checks   = 0;
  int    failures = 0;
  logic  stall_prev = 1'b0;
  res_t  stall_hold = '0;
  res_t  pend_exp;
  string pend_name;
  logic  acc;
  int    ready_mode = 0;  // 0: hold, 1: 1,0,0,1 pattern, 2: random
  int    cyc = 0;
  vec_t  vecs[NV];

  // Reference model. It applies the shift one bit at a time, n times, and tracks the
  // last bit shifted out. An amount of 0 leaves the carry at cin.
  function automatic res_t ref_model(input int w, input logic [1:0] o, input logic im,
                                     input logic [31:0] d, input logic [7:0] a, input logic c_in);
    logic [31:0] x, m;
    logic        c;
    int          n;
    m = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    x = d & m;
    c = c_in;
    n = int'(a);
    if (im && n == 0 && o == 2'd3) begin
      c = x[0];
      x = (x >> 1) | ({31'd0, c_in} << (w - 1));
      return {c, x};
    end
    if (im && n == 0 && (o == 2'd1 || o == 2'd2)) n = w;
    for (int i = 0; i < n; i++) begin
      case (o)
        2'd0:    begin c = x[w-1]; x = (x << 1) & m; end
        2'd1:    begin c = x[0];   x = x >> 1; end
        2'd2:    begin c = x[0];   x = (x >> 1) | ({31'd0, x[w-1]} << (w - 1)); end
        default: begin c = x[0];   x = (x >> 1) | ({31'd0, x[0]} << (w - 1)); end
      endcase
    end
    return {c, x};
  endfunction

  function automatic vec_t mk(input string nm, input logic [1:0] o, input logic im,
                              input logic [31:0] d, input logic [7:0] a, input logic c,
                              input logic [31:0] ed, input logic ec);
    vec_t v;
    v.name = nm; v.op = o; v.imm = im; v.d = d; v.amt = a; v.cin = c;
    v.exp_d = ed; v.exp_c = ec;
    return v;
  endfunction

  task automatic check(input string name, input res_t act, input res_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // One clock cycle. At the falling edge, sample the handshakes, score outputs and check
  // stall rules. Then advance to just after the rising edge.
  task automatic step();
    @(negedge clk);
    acc = in_valid && in_ready;
    if (acc) begin
      exp_q.push_back(pend_exp);
      name_q.push_back(pend_name);
    end
    if (!in_ready)
      check("in_ready_low_only_when_stalled", res_t'({out_valid, out_ready}), res_t'(2'b10));
    if (stall_prev) begin
      check("stall_valid_hold", res_t'(out_valid), res_t'(1));
      check("stall_data_hold", res_t'({cout, data_out}), stall_hold);
    end
    stall_prev = out_valid && !out_ready;
    stall_hold = {cout, data_out};
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got %h, required no output", {cout, data_out});
      end else begin
        check(name_q.pop_front(), {cout, data_out}, exp_q.pop_front());
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (ready_mode == 1)      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
    else if (ready_mode == 2) out_ready = 1'($urandom_range(0, 1));
  endtask

  // Present one op and keep it valid until it is accepted.
  task automatic send(input string nm, input logic [1:0] o, input logic im, input logic [31:0] d,
                      input logic [7:0] a, input logic c, input res_t e);
    int waited;
    in_valid = 1'b1; op = o; imm_form = im; data_in = d; amount = a; cin = c;
    pend_exp = e; pend_name = nm;
    waited = 0;
    do begin
      step();
      waited++;
    end while (!acc && waited < MAX_WAIT);
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout_%s: in_ready=0 for %0d cycles, required acceptance", nm, waited);
    end
  endtask

  task automatic drain();
    int waited;
    in_valid = 1'b0;
    waited = 0;
    while (exp_q.size() > 0 && waited < MAX_WAIT) begin
      step();
      waited++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d results pending, required 0", exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
  endtask

  task automatic random_op(input string nm);
    logic [1:0]  o;
    logic        im, c;
    logic [31:0] d;
    logic [7:0]  a;
    o  = 2'($urandom_range(0, 3));
    im = ($urandom_range(0, 3) == 0);
    d  = $urandom;
    c  = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 5))
      0:       a = 8'd0;
      1:       a = 8'(W - 1);
      2:       a = 8'(W);
      3:       a = 8'(W + 1);
      4:       a = 8'($urandom_range(0, 255));
      default: a = 8'($urandom_range(1, W - 1));
    endcase
    send(nm, o, im, d, a, c, ref_model(W, o, im, d, a, c));
  endtask

  // Send one op to the 16-bit instance and compare its single result.
  task automatic run16(input string nm, input logic [1:0] o, input logic im, input logic [15:0] d,
                       input logic [7:0] a, input logic c, input logic [15:0] ed, input logic ec);
    int waited;
    op16 = o; imm16 = im; d16_in = d; amt16 = a; cin16 = c; in_valid16 = 1'b1;
    @(negedge clk);
    check({nm, "_in_ready"}, res_t'(in_ready16), res_t'(1));
    @(posedge clk);
    #1;
    in_valid16 = 1'b0;
    waited = 0;
    @(negedge clk);
    while (!out_valid16 && waited < MAX_WAIT) begin
      @(negedge clk);
      waited++;
    end
    check(nm, res_t'({out_valid16, cout16, d16_out}), res_t'({1'b1, ec, ed}));
    @(posedge clk);
    #1;
  endtask

  // Watchdog: stop the run if it stalls.
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- vector table ----------------
    vecs[0]  = mk("lsl_32",      2'd0, 1'b0, 32'h8000_0001, 8'd32, 1'b1, 32'h0000_0000, 1'b1);
    vecs[1]  = mk("lsl_33",      2'd0, 1'b0, 32'h8000_0001, 8'd33, 1'b1, 32'h0000_0000, 1'b0);
    vecs[2]  = mk("lsr_32",      2'd1, 1'b0, 32'h8000_0001, 8'd32, 1'b1, 32'h0000_0000, 1'b1);
    vecs[3]  = mk("asr_40",      2'd2, 1'b0, 32'h8000_0001, 8'd40, 1'b1, 32'hFFFF_FFFF, 1'b1);
    vecs[4]  = mk("ror_32",      2'd3, 1'b0, 32'h8000_0001, 8'd32, 1'b1, 32'h8000_0001, 1'b1);
    vecs[5]  = mk("lsl_0",       2'd0, 1'b0, 32'h8000_0001, 8'd0,  1'b1, 32'h8000_0001, 1'b1);
    vecs[6]  = mk("imm_lsr_0",   2'd1, 1'b1, 32'h8000_0003, 8'd0,  1'b1, 32'h0000_0000, 1'b1);
    vecs[7]  = mk("imm_asr_0",   2'd2, 1'b1, 32'h8000_0003, 8'd0,  1'b1, 32'hFFFF_FFFF, 1'b1);
    vecs[8]  = mk("imm_rrx",     2'd3, 1'b1, 32'h8000_0003, 8'd0,  1'b1, 32'hC000_0001, 1'b1);
    vecs[9]  = mk("ror_4",       2'd3, 1'b0, 32'h1234_5678, 8'd4,  1'b0, 32'h8123_4567, 1'b1);
    vecs[10] = mk("asr_4",       2'd2, 1'b0, 32'hF000_0010, 8'd4,  1'b0, 32'hFF00_0001, 1'b0);
    vecs[11] = mk("ror_36",      2'd3, 1'b0, 32'h1234_5678, 8'd36, 1'b0, 32'h8123_4567, 1'b1);
    vecs[12] = mk("lsr_31",      2'd1, 1'b0, 32'h8000_0001, 8'd31, 1'b1, 32'h0000_0001, 1'b0);
    vecs[13] = mk("lsl_31",      2'd0, 1'b0, 32'h0000_0003, 8'd31, 1'b0, 32'h8000_0000, 1'b1);
    vecs[14] = mk("lsr_1",       2'd1, 1'b0, 32'h8000_0001, 8'd1,  1'b0, 32'h4000_0000, 1'b1);
    vecs[15] = mk("imm_lsl_1",   2'd0, 1'b1, 32'h8000_0001, 8'd1,  1'b0, 32'h0000_0002, 1'b1);
    vecs[16] = mk("asr_31",      2'd2, 1'b0, 32'h8000_0000, 8'd31, 1'b0, 32'hFFFF_FFFF, 1'b0);
    vecs[17] = mk("lsr_255",     2'd1, 1'b0, 32'hFFFF_FFFF, 8'd255, 1'b1, 32'h0000_0000, 1'b0);
    vecs[18] = mk("imm_lsl_0",   2'd0, 1'b1, 32'h1234_5678, 8'd0,  1'b0, 32'h1234_5678, 1'b0);

    // ---------------- reset ----------------
    rst = 1'b1;
    in_valid = 1'b0; op = 2'd0; imm_form = 1'b0; data_in = '0; amount = '0; cin = 1'b0;
    out_ready = 1'b1;
    in_valid16 = 1'b0; op16 = 2'd0; imm16 = 1'b0; d16_in = '0; amt16 = '0; cin16 = 1'b0;
    out_ready16 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", res_t'(out_valid), res_t'(0));
    check("reset_data_cout", res_t'({cout, data_out}), res_t'(0));
    check("reset_in_ready", res_t'(in_ready), res_t'(1));
    check("reset_out_valid16", res_t'(out_valid16), res_t'(0));
    @(posedge clk);
    #1;

    // ---------------- table vectors, back to back ----------------
    ready_mode = 0;
    out_ready  = 1'b1;
    for (int i = 0; i < NV; i++)
      send(vecs[i].name, vecs[i].op, vecs[i].imm, vecs[i].d, vecs[i].amt, vecs[i].cin,
           {vecs[i].exp_c, vecs[i].exp_d});
    drain();

    // ---------------- backpressure: 8 random ops, out_ready 1,0,0,1,... ----------------
    ready_mode = 1;
    for (int i = 0; i < 8; i++) random_op($sformatf("bp_%0d", i));
    drain();

    // ---------------- random stream with random out_ready ----------------
    ready_mode = 2;
    for (int i = 0; i < 40; i++) random_op($sformatf("rnd_%0d", i));
    drain();

    // ---------------- reset mid-stream ----------------
    ready_mode = 0;
    out_ready  = 1'b0;
    in_valid = 1'b1; op = 2'd0; imm_form = 1'b0; data_in = 32'hDEAD_BEEF; amount = 8'd4; cin = 1'b0;
    pend_exp = ref_model(W, op, imm_form, data_in, amount, cin); pend_name = "pre_reset_a";
    step();
    op = 2'd1; data_in = 32'h0F0F_0F0F; amount = 8'd8; cin = 1'b1;
    pend_exp = ref_model(W, op, imm_form, data_in, amount, cin); pend_name = "pre_reset_b";
    step();
    in_valid = 1'b0;
    step();
    check("occupied_before_reset", res_t'(out_valid), res_t'(1));
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_out_valid", res_t'(out_valid), res_t'(0));
    check("async_reset_data_cout", res_t'({cout, data_out}), res_t'(0));
    exp_q.delete();
    name_q.delete();
    stall_prev = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    out_ready = 1'b1;
    send("post_reset_first", 2'd3, 1'b0, 32'h0000_00F1, 8'd4, 1'b0, {1'b0, 32'h1000_000F});
    drain();

    // ---------------- width generality (WIDTH=16) ----------------
    run16("w16_lsl_16", 2'd0, 1'b0, 16'h0001, 8'd16, 1'b0, 16'h0000, 1'b1);
    run16("w16_ror_17", 2'd3, 1'b0, 16'h0003, 8'd17, 1'b0, 16'h8001, 1'b1);
    run16("w16_asr_20", 2'd2, 1'b0, 16'h8000, 8'd20, 1'b0, 16'hFFFF, 1'b1);
    run16("w16_rrx",    2'd3, 1'b1, 16'h0002, 8'd0,  1'b1, 16'h8001, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
